// File: rtl/fifo_dot_mac.sv
// fifo_dot_mac: drains LEN (A, B) pairs from two FIFOs in lockstep and accumulates their dot product.
// Optional build macro ACC_SAT_EN: saturate the accumulator instead of wrapping.
module fifo_dot_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_rden,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_rden,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam int CNT_W  = $clog2(LEN + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    consumed;
  logic                valid;
  logic                rden;
  logic [PROD_W-1:0]   product;
  logic [ACC_WIDTH-1:0] next_acc;

  assign rden    = (state == RUN) && !a_empty && !b_empty && (issued < CNT_W'(LEN));
  assign a_rden  = rden;
  assign b_rden  = rden;
  assign product = PROD_W'(a_data) * PROD_W'(b_data);

`ifdef ACC_SAT_EN
  // One extra carry bit detects overflow so the sum can clamp at all-ones.
  logic [ACC_WIDTH:0] sum;
  assign sum      = {1'b0, result} + (ACC_WIDTH + 1)'(product);
  assign next_acc = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
  assign next_acc = result + ACC_WIDTH'(product);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      issued   <= '0;
      consumed <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      valid <= rden;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            result   <= '0;
            issued   <= '0;
            consumed <= '0;
          end
        end
        RUN: begin
          if (rden)
            issued <= issued + CNT_W'(1);
          // valid marks the cycle the popped pair is present on a_data/b_data.
          if (valid) begin
            result   <= next_acc;
            consumed <= consumed + CNT_W'(1);
            if (consumed == CNT_W'(LEN - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
